// File: rtl/nibble_code_lock.sv
// nibble_code_lock: digit-by-digit code entry lock with fail counting and timed lockout.
// Optional CODE_LOCK_AUTO_RELOCK_EN relocks after UNLOCK_TIMEOUT idle cycles in UNLOCKED.
module nibble_code_lock #(
  parameter int DIGITS = 4,
  parameter logic [DIGITS*4-1:0] RESET_CODE = 16'h1234,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int UNLOCK_TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          din,
  input  logic                din_valid,
  input  logic                clear,
  input  logic                relock,
  input  logic                load_code,
  input  logic [DIGITS*4-1:0] code_in,
  output logic                unlocked,
  output logic                locked_out,
  output logic                fail_pulse,
  output logic [2:0]          digit_idx,
  output logic [2:0]          fail_cnt
);
  // state bits double as the unlocked/locked_out flops
  localparam logic [1:0] ENTRY = 2'b00, UNLOCKED = 2'b01, LOCKOUT = 2'b10;
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0] LAST = 3'(DIGITS - 1);
  localparam logic [2:0] MAXF = 3'(MAX_FAILS);
  logic [1:0] state;
  logic [DIGITS*4-1:0] code;
  logic [TW-1:0] timer;
  logic mismatch;
  logic digit_miss;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
  localparam int RW = $clog2(UNLOCK_TIMEOUT + 1);
  logic [RW-1:0] idle_cnt;
`endif
  assign digit_miss = din != code[{digit_idx, 2'b00} +: 4];
  assign unlocked = state[0];
  assign locked_out = state[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ENTRY;
      code <= RESET_CODE;
      digit_idx <= '0;
      mismatch <= 1'b0;
      fail_cnt <= '0;
      timer <= '0;
      fail_pulse <= 1'b0;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
      idle_cnt <= '0;
`endif
    end else begin
      fail_pulse <= 1'b0;
      if (state == ENTRY) begin
        if (clear) begin
          digit_idx <= '0;
          mismatch <= 1'b0;
        end else if (din_valid) begin
          if (digit_idx == LAST) begin
            digit_idx <= '0;
            mismatch <= 1'b0;
            if (!mismatch && !digit_miss) begin
              state <= UNLOCKED;
              fail_cnt <= '0;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
              idle_cnt <= '0;
`endif
            end else begin
              fail_pulse <= 1'b1;
              fail_cnt <= fail_cnt + 3'd1;
              if (fail_cnt + 3'd1 == MAXF) begin
                state <= LOCKOUT;
                timer <= TW'(LOCKOUT_CYCLES);
              end
            end
          end else begin
            mismatch <= mismatch | digit_miss;
            digit_idx <= digit_idx + 3'd1;
          end
        end
      end else if (state == UNLOCKED) begin
        if (load_code) code <= code_in;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
        idle_cnt <= load_code ? '0 : idle_cnt + RW'(1);
        if (relock || (!load_code && idle_cnt == RW'(UNLOCK_TIMEOUT - 1))) begin
`else
        if (relock) begin
`endif
          state <= ENTRY;
          digit_idx <= '0;
        end
      end else begin
        if (timer == TW'(1)) begin
          state <= ENTRY;
          fail_cnt <= '0;
          timer <= '0;
        end else begin
          timer <= timer - TW'(1);
        end
      end
    end
endmodule

// File: tb/tb_nibble_code_lock.sv
// tb_nibble_code_lock: scoreboard bench for nibble_code_lock with default parameters.
module tb_nibble_code_lock;
  logic clk = 0, rst_n = 0, din_valid = 0, clear = 0, relock = 0, load_code = 0;
  logic [3:0] din = '0;
  logic [15:0] code_in = '0;
  logic unlocked, locked_out, fail_pulse;
  logic [2:0] digit_idx, fail_cnt;
  typedef struct packed {logic u; logic lo; logic fp; logic [2:0] idx; logic [2:0] fc;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  nibble_code_lock dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
    .relock(relock), .load_code(load_code), .code_in(code_in), .unlocked(unlocked),
    .locked_out(locked_out), .fail_pulse(fail_pulse), .digit_idx(digit_idx), .fail_cnt(fail_cnt)
  );
  function automatic exp_t obs();
    return {unlocked, locked_out, fail_pulse, digit_idx, fail_cnt};
  endfunction
  function automatic exp_t mk(input logic u, lo, fp, input logic [2:0] idx, fc);
    return {u, lo, fp, idx, fc};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic attempt(input logic [3:0] a, b, c, d, input exp_t x);
    din_valid = 1;
    din = a; step();
    din = b; step();
    din = c; step();
    din = d; q.push_back(x); step();
    din_valid = 0;
  endtask
  task automatic test_reset();
    #3;
    q.push_back(mk(0, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL reset got=%b exp=%b", obs(), e); end
    step();
    rst_n = 1;
    step();
  endtask
  task automatic test_unlock();
    attempt(4'h4, 4'h3, 4'h2, 4'h1, mk(1, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL unlock got=%b exp=%b", obs(), e); end
    q.push_back(mk(1, 0, 0, 0, 0)); step();
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL unlock_hold got=%b exp=%b", obs(), e); end
    relock = 1; q.push_back(mk(0, 0, 0, 0, 0)); step(); relock = 0;
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL relock got=%b exp=%b", obs(), e); end
  endtask
  task automatic test_fail();
    attempt(4'h4, 4'h3, 4'h9, 4'h1, mk(0, 0, 1, 0, 1));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL fail_attempt got=%b exp=%b", obs(), e); end
    q.push_back(mk(0, 0, 0, 0, 1)); step();
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL fail_pulse_once got=%b exp=%b", obs(), e); end
    attempt(4'h4, 4'h3, 4'h2, 4'h1, mk(1, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL retry_unlock got=%b exp=%b", obs(), e); end
    relock = 1; step(); relock = 0;
  endtask
  task automatic test_clear();
    attempt(4'h0, 4'h0, 4'h0, 4'h0, mk(0, 0, 1, 0, 1));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL clear_pre_fail got=%b exp=%b", obs(), e); end
    din_valid = 1; din = 4'h4; step(); din = 4'h3; q.push_back(mk(0, 0, 0, 2, 1)); step();
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL partial_idx got=%b exp=%b", obs(), e); end
    clear = 1; din = 4'h2; q.push_back(mk(0, 0, 0, 0, 1)); step(); clear = 0; din_valid = 0;
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL clear got=%b exp=%b", obs(), e); end
    attempt(4'h4, 4'h3, 4'h2, 4'h1, mk(1, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL after_clear got=%b exp=%b", obs(), e); end
    relock = 1; step(); relock = 0;
  endtask
  task automatic test_lockout();
    logic [3:0] good [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    int n = 1;
    for (int k = 1; k <= 3; k++) begin
      attempt(4'h0, 4'h0, 4'h0, 4'h0, mk(0, k == 3, 1, 0, 3'(k)));
      e = q.pop_front(); tests++;
      if (obs() !== e) begin fails++; $display("FAIL lock_attempt%0d got=%b exp=%b", k, obs(), e); end
    end
    din_valid = 1;
    for (int i = 0; i < 40; i++) begin
      din = good[i % 4];
      step();
      if (locked_out) n++; else break;
    end
    din_valid = 0;
    tests++;
    if (n !== 16) begin fails++; $display("FAIL lockout_len got=%0d exp=16", n); end
    q.push_back(mk(0, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL lockout_exit got=%b exp=%b", obs(), e); end
    attempt(4'h4, 4'h3, 4'h2, 4'h1, mk(1, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL post_lock_unlock got=%b exp=%b", obs(), e); end
  endtask
  task automatic test_load_code();
    load_code = 1; relock = 1; code_in = 16'hABCD;
    q.push_back(mk(0, 0, 0, 0, 0)); step();
    load_code = 0; relock = 0; code_in = '0;
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL load_relock got=%b exp=%b", obs(), e); end
    attempt(4'h4, 4'h3, 4'h2, 4'h1, mk(0, 0, 1, 0, 1));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL old_code got=%b exp=%b", obs(), e); end
    attempt(4'hD, 4'hC, 4'hB, 4'hA, mk(1, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL new_code got=%b exp=%b", obs(), e); end
    relock = 1; step(); relock = 0;
  endtask
  task automatic test_reset_mid();
    for (int k = 1; k <= 3; k++) begin
      attempt(4'h0, 4'h0, 4'h0, 4'h0, mk(0, k == 3, 1, 0, 3'(k)));
      e = q.pop_front(); tests++;
      if (obs() !== e) begin fails++; $display("FAIL rm_attempt%0d got=%b exp=%b", k, obs(), e); end
    end
    step(); step(); step();
    #2 rst_n = 0;
    #1 q.push_back(mk(0, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL async_reset got=%b exp=%b", obs(), e); end
    step();
    rst_n = 1;
    step();
    attempt(4'h4, 4'h3, 4'h2, 4'h1, mk(1, 0, 0, 0, 0));
    e = q.pop_front(); tests++;
    if (obs() !== e) begin fails++; $display("FAIL code_reverted got=%b exp=%b", obs(), e); end
  endtask
  task automatic test_timeout();
    int n = 1;
    for (int i = 0; i < 110; i++) begin
      step();
      if (unlocked) n++; else break;
    end
    tests++;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
    if (n !== 32) begin fails++; $display("FAIL auto_relock got=%0d exp=32", n); end
`else
    if (n !== 111 || unlocked !== 1'b1) begin
      fails++; $display("FAIL no_auto_relock got=%0d cycles exp=111", n);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_unlock();
    test_fail();
    test_clear();
    test_lockout();
    test_load_code();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
